reaction_timer_core: RTL and testbench
======================================

// Module: reaction_timer_core
// PURPOSE
//  Parametrised start-light reaction timer: steps N_LIGHTS lamps on at a fixed ms rate,
//  waits a pseudo-random hold, then times the player's response in ms. Adds false-start
//  detection, saturation/overflow flag and a best-time register. Sits between the board
//  KEY/LEDR pins and the bin2bcd/7-seg display path. Owns its own ms prescaler.
// PARAMETERS
//  CLK_HZ        50_000_000  input clock frequency; ms tick every CLK_HZ/1000 clocks
//  N_LIGHTS      10          number of start lamps (1..16)
//  LIGHT_MS      500         ms between successive lamps turning on
//  LFSR_W        7           random-hold LFSR width (5..16, maximal-length taps from package)
//  HOLD_MIN_MS   250         minimum hold; hold = HOLD_MIN_MS + LFSR value (ms)
//  CNT_W         14          reaction counter width
//  MAX_MS        9999        saturation value for time_ms (< 2**CNT_W)
// PORTS
//  CLOCK_50     in   1        system clock
//  RESET_N      in   1        asynchronous active-low reset
//  start        in   1        synchronous, debounced, active-high start request
//  react        in   1        synchronous, debounced, active-high player button (level)
//  clear_best   in   1        synchronous pulse: best_ms <- MAX_MS
//  lights       out  N_LIGHTS lamp outputs (bit 0 lights first)
//  time_ms      out  CNT_W    last reaction time, held until next start
//  time_valid   out  1        one-cycle pulse when time_ms updates
//  false_start  out  1        level; react rising edge before lamps went out
//  overflow     out  1        level; no react before MAX_MS
//  best_ms      out  CNT_W    smallest valid time since reset/clear_best
//  busy         out  1        high in LIGHTS, HOLD, TIMING
// BEHAVIOUR
//  Reset: state IDLE, lights=0, time_ms=0, time_valid=0, false_start=0, overflow=0,
//   best_ms=MAX_MS, busy=0, LFSR=1 (never all-zero), prescaler=0.
//  Tick: prescaler counts 0..CLK_HZ/1000-1, tick is 1 clock wide on terminal count;
//   prescaler cleared on start acceptance, so first tick arrives CLK_HZ/1000 clocks later.
//  LFSR advances every clock in all states (free-running entropy source).
//  react_edge = react & ~react_q (registered previous value); only edges are used.
//  FSM:
//   IDLE  : start -> LIGHTS, lights=0, clear false_start/overflow, step cnt=0.
//   LIGHTS: every LIGHT_MS ticks shift in one lamp (lights={lights,1'b1}); after lamp
//           N_LIGHTS has been on LIGHT_MS ticks, capture hold=HOLD_MIN_MS+LFSR -> HOLD.
//   HOLD  : all lamps on; count ticks; on reaching hold, lights=0, cnt=0 -> TIMING.
//   TIMING: cnt+1 per tick. react_edge -> time_ms=cnt, time_valid pulse, best_ms=min
//           -> DONE. cnt==MAX_MS on tick -> time_ms=MAX_MS, overflow=1 -> DONE (best untouched).
//   DONE  : display state; start -> LIGHTS (as IDLE).
//   FALSE : entered on react_edge in LIGHTS or HOLD; lights=0, false_start=1,
//           time_ms unchanged, no time_valid; start -> LIGHTS.
//  Simultaneous events: start and react_edge same cycle in IDLE/DONE/FALSE -> start wins,
//   edge discarded. react_edge and saturation tick same cycle -> react wins (time=MAX_MS,
//   overflow=0, best updated). clear_best with time_valid same cycle -> clear wins.
//  start while busy is ignored. react edge in TIMING at cnt=0 is valid: time_ms=0.
//  RESET_N low mid-run: immediate return to reset values, best_ms lost.
//  Width rules: cnt saturates, never wraps; hold counter is max(CNT_W, LFSR_W+1) bits.
// STRUCTURE
//  Shared header reaction_defs.vh: state encodings (IDLE,LIGHTS,HOLD,TIMING,DONE,FALSE),
//   LFSR tap masks per width 5..16.
//  One sub-module: lfsr_prbs #(LFSR_W) (clock, reset, free-running, parallel out).
//  Prescaler, edge detect, FSM and counters stay in this module.
// TESTING (CLK_HZ=10_000 -> tick every 10 clocks, N_LIGHTS=4, LIGHT_MS=2, HOLD_MIN_MS=3)
//  1 Reset then start pulse -> lights 0001,0011,0111,1111 at 20-clock spacing, busy=1.
//  2 Force LFSR=5: hold=8 ticks; react edge 7 ticks after lights=0 -> time_ms=7,
//    time_valid one pulse, best_ms=7; second run time 12 -> best_ms stays 7.
//  3 React edge during LIGHTS (lights=0011) -> lights=0, false_start=1, time_ms held,
//    no time_valid; next start clears false_start.
//  4 MAX_MS=20, no react -> time_ms=20, overflow=1, best_ms unchanged; react held high
//    entering TIMING (no edge) must not stop timer.
//  5 react edge coincident with saturation tick -> time_ms=20, overflow=0, time_valid=1.
//  6 RESET_N low in HOLD -> all outputs to reset values asynchronously; clear_best with
//    time_valid same cycle -> best_ms=MAX_MS.

Source files
------------

// File: rtl/reaction_timer_core_pkg.sv
// Shared definitions for the reaction timer: FSM state encoding, LFSR feedback masks
// and small elaboration-time helpers.
package reaction_timer_core_pkg;

   localparam int MS_PER_S = 1000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LIGHTS = 3'd1,
      ST_HOLD   = 3'd2,
      ST_TIMING = 3'd3,
      ST_DONE   = 3'd4,
      ST_FALSE  = 3'd5
   } state_e;

   // Galois feedback masks: primitive polynomial with the x^w term removed.
   function automatic logic [15:0] lfsr_taps(input int w);
      logic [15:0] taps;
      case (w)
         5:       taps = 16'h0009;
         6:       taps = 16'h0021;
         7:       taps = 16'h0041;
         8:       taps = 16'h0071;
         9:       taps = 16'h0021;
         10:      taps = 16'h0081;
         11:      taps = 16'h0201;
         12:      taps = 16'h0053;
         13:      taps = 16'h001B;
         14:      taps = 16'h002B;
         15:      taps = 16'h4001;
         16:      taps = 16'hA011;
         default: taps = 16'h0041;
      endcase
      return taps;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reaction_timer_core_lfsr_prbs.sv
// Free-running maximal-length Galois LFSR; seeds to 1 so it can never lock up at zero.
module lfsr_prbs
   import reaction_timer_core_pkg::*;
#(
   parameter int W = 7
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   output logic [W-1:0] value_o
);

   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

   logic [W-1:0] state_q;
   logic [W-1:0] state_d;

   assign state_d = (state_q << 1) ^ (state_q[W-1] ? TAPS : '0);
   assign value_o = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= W'(1);
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/reaction_timer_core.sv
// Start-light reaction timer: lamp sequence, random hold, ms response timing with
// false-start detection, saturation flag and best-time tracking.
module reaction_timer_core
   import reaction_timer_core_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int N_LIGHTS    = 10,
   parameter int LIGHT_MS    = 500,
   parameter int LFSR_W      = 7,
   parameter int HOLD_MIN_MS = 250,
   parameter int CNT_W       = 14,
   parameter int MAX_MS      = 9999
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic                start,
   input  logic                react,
   input  logic                clear_best,
   output logic [N_LIGHTS-1:0] lights,
   output logic [CNT_W-1:0]    time_ms,
   output logic                time_valid,
   output logic                false_start,
   output logic                overflow,
   output logic [CNT_W-1:0]    best_ms,
   output logic                busy
);

   localparam int TICK_DIV = CLK_HZ / MS_PER_S;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW       = (LIGHT_MS > 1) ? $clog2(LIGHT_MS) : 1;
   localparam int HW       = max_int(CNT_W, LFSR_W + 1);

   state_e              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                react_q;
   logic [N_LIGHTS-1:0] lights_q, lights_d;
   logic [SW-1:0]       step_q, step_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [HW-1:0]       hcnt_q, hcnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    time_q, time_d;
   logic                valid_q, valid_d;
   logic                fs_q, fs_d;
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    best_q, best_d;
   logic [LFSR_W-1:0]   lfsr_val;
   logic                tick;
   logic                react_edge;
   logic                start_ok;

   lfsr_prbs #(.W(LFSR_W)) u_lfsr (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .value_o (lfsr_val)
   );

   assign tick       = (presc_q == PW'(TICK_DIV - 1));
   assign react_edge = react & ~react_q;
   assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FALSE);
   // Restarting the prescaler on start aligns every lamp step to the start request.
   assign presc_d    = (start_ok || tick) ? '0 : presc_q + PW'(1);

   always_comb begin
      state_d  = state_q;
      lights_d = lights_q;
      step_d   = step_q;
      hold_d   = hold_q;
      hcnt_d   = hcnt_q;
      cnt_d    = cnt_q;
      time_d   = time_q;
      valid_d  = 1'b0;
      fs_d     = fs_q;
      ovf_d    = ovf_q;
      best_d   = best_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_FALSE: begin
            if (start) begin
               state_d  = ST_LIGHTS;
               lights_d = '0;
               fs_d     = 1'b0;
               ovf_d    = 1'b0;
               step_d   = '0;
            end
         end
         ST_LIGHTS: begin
            if (react_edge) begin
               state_d  = ST_FALSE;
               lights_d = '0;
               fs_d     = 1'b1;
            end else if (tick) begin
               if (step_q == SW'(LIGHT_MS - 1)) begin
                  step_d = '0;
                  if (&lights_q) begin
                     hold_d  = HW'(HOLD_MIN_MS) + HW'(lfsr_val);
                     hcnt_d  = '0;
                     state_d = ST_HOLD;
                  end else begin
                     lights_d = (lights_q << 1) | N_LIGHTS'(1);
                  end
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
         end
         ST_HOLD: begin
            if (react_edge) begin
               state_d  = ST_FALSE;
               lights_d = '0;
               fs_d     = 1'b1;
            end else if (tick) begin
               if (hcnt_q + HW'(1) == hold_q) begin
                  lights_d = '0;
                  cnt_d    = '0;
                  state_d  = ST_TIMING;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
         end
         ST_TIMING: begin
            // A press always beats the saturation tick, so check it first.
            if (react_edge) begin
               time_d  = cnt_q;
               valid_d = 1'b1;
               if (cnt_q < best_q) best_d = cnt_q;
               state_d = ST_DONE;
            end else if (tick) begin
               if (cnt_q == CNT_W'(MAX_MS)) begin
                  time_d  = CNT_W'(MAX_MS);
                  ovf_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_best) best_d = CNT_W'(MAX_MS);
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         presc_q  <= '0;
         react_q  <= 1'b0;
         lights_q <= '0;
         step_q   <= '0;
         hold_q   <= '0;
         hcnt_q   <= '0;
         cnt_q    <= '0;
         time_q   <= '0;
         valid_q  <= 1'b0;
         fs_q     <= 1'b0;
         ovf_q    <= 1'b0;
         best_q   <= CNT_W'(MAX_MS);
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         react_q  <= react;
         lights_q <= lights_d;
         step_q   <= step_d;
         hold_q   <= hold_d;
         hcnt_q   <= hcnt_d;
         cnt_q    <= cnt_d;
         time_q   <= time_d;
         valid_q  <= valid_d;
         fs_q     <= fs_d;
         ovf_q    <= ovf_d;
         best_q   <= best_d;
      end
   end

   assign lights      = lights_q;
   assign time_ms     = time_q;
   assign time_valid  = valid_q;
   assign false_start = fs_q;
   assign overflow    = ovf_q;
   assign best_ms     = best_q;
   assign busy        = (state_q == ST_LIGHTS) || (state_q == ST_HOLD) || (state_q == ST_TIMING);

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed-plus-random bench for reaction_timer_core; expected timing comes from an
// event-level model (tick arithmetic plus x^n mod p for the hold value).
module tb_reaction_timer_core;

   localparam int CLK_HZ      = 10_000;
   localparam int N_LIGHTS    = 4;
   localparam int LIGHT_MS    = 2;
   localparam int LFSR_W      = 7;
   localparam int HOLD_MIN_MS = 3;
   localparam int CNT_W       = 14;
   localparam int MAX_MS      = 20;
   localparam int P           = CLK_HZ / 1000;
   localparam int STEP        = P * LIGHT_MS;
   localparam int ALL_ON      = (1 << N_LIGHTS) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                start = 1'b0;
   logic                react = 1'b0;
   logic                clear_best = 1'b0;
   logic [N_LIGHTS-1:0] lights;
   logic [CNT_W-1:0]    time_ms;
   logic                time_valid;
   logic                false_start;
   logic                overflow;
   logic [CNT_W-1:0]    best_ms;
   logic                busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc;
   int best_model;
   int time_model;

   reaction_timer_core #(
      .CLK_HZ(CLK_HZ), .N_LIGHTS(N_LIGHTS), .LIGHT_MS(LIGHT_MS), .LFSR_W(LFSR_W),
      .HOLD_MIN_MS(HOLD_MIN_MS), .CNT_W(CNT_W), .MAX_MS(MAX_MS)
   ) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .react(react),
      .clear_best(clear_best), .lights(lights), .time_ms(time_ms),
      .time_valid(time_valid), .false_start(false_start), .overflow(overflow),
      .best_ms(best_ms), .busy(busy)
   );

   always #5 clk = ~clk;

   // Number of rising edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // x^n mod (x^7 + x^6 + 1): the hold entropy source seeded with 1 at reset.
   function automatic int lfsr_model(input int n);
      int v = 1;
      for (int i = 0; i < n; i++) begin
         v = v << 1;
         if ((v & 32'h80) != 0) v = v ^ 32'hC1;
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != target) begin
         miscompares++;
         $display("FAIL wait_cyc: observed %0d expected %0d", cyc, target);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_lights"}, 32'(lights), 0);
      check({tag, "_time"}, 32'(time_ms), 0);
      check({tag, "_valid"}, 32'(time_valid), 0);
      check({tag, "_fs"}, 32'(false_start), 0);
      check({tag, "_ovf"}, 32'(overflow), 0);
      check({tag, "_best"}, 32'(best_ms), MAX_MS);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   // Call at a negedge with the DUT idle; returns accept edge and TIMING entry edge.
   task automatic start_run(output int e0, output int t0);
      int h;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = cyc;
      h  = HOLD_MIN_MS + lfsr_model(e0 + STEP * (N_LIGHTS + 1) - 1);
      t0 = e0 + STEP * (N_LIGHTS + 1) + P * h;
      check("busy_start", 32'(busy), 1);
      check("lights_start", 32'(lights), 0);
      check("fs_start", 32'(false_start), 0);
   endtask

   task automatic do_react(input int t0, input int t, input int off, input bit clr);
      int exp_best;
      wait_cyc(t0 + P * t + off);
      react = 1'b1;
      clear_best = clr;
      @(negedge clk);
      clear_best = 1'b0;
      exp_best = clr ? MAX_MS : ((t < best_model) ? t : best_model);
      check("valid_pulse", 32'(time_valid), 1);
      check("time_ms", 32'(time_ms), t);
      check("best_ms", 32'(best_ms), exp_best);
      check("busy_done", 32'(busy), 0);
      best_model = exp_best;
      time_model = t;
      @(negedge clk);
      check("valid_clear", 32'(time_valid), 0);
      react = 1'b0;
      $display("run: t0=%0d time=%0d best=%0d clear=%0d", t0, t, exp_best, clr);
   endtask

   initial begin
      int e0, t0, t;
      best_model = MAX_MS;
      time_model = 0;
      #1 rst_n = 1'b0;
      #11;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      repeat ($urandom_range(1, 40)) @(negedge clk);

      // Lamp sequence, with a start pulse while busy that must be ignored.
      start_run(e0, t0);
      for (int k = 1; k <= N_LIGHTS; k++) begin
         wait_cyc(e0 + STEP * k - 1);
         check("lights_before", 32'(lights), (1 << (k - 1)) - 1);
         wait_cyc(e0 + STEP * k);
         check("lights_after", 32'(lights), (1 << k) - 1);
         check("busy_lights", 32'(busy), 1);
         if (k == 2) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      wait_cyc(t0 - 1);
      check("hold_lights", 32'(lights), ALL_ON);
      check("hold_busy", 32'(busy), 1);
      wait_cyc(t0);
      check("timing_lights", 32'(lights), 0);
      check("timing_busy", 32'(busy), 1);
      do_react(t0, 7, $urandom_range(0, P - 1), 1'b0);

      // Start and react edge together from DONE: start wins, slower time keeps best.
      repeat ($urandom_range(1, 40)) @(negedge clk);
      react = 1'b1;
      start_run(e0, t0);
      wait_cyc(e0 + 50);
      react = 1'b0;
      wait_cyc(e0 + 60);
      check("simul_fs", 32'(false_start), 0);
      check("simul_lights", 32'(lights), 7);
      do_react(t0, 12, $urandom_range(0, P - 1), 1'b0);

      // Random reaction times, including the zero-count edge case.
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(1, 60)) @(negedge clk);
         start_run(e0, t0);
         t = (r == 0) ? 0 : int'($urandom_range(0, MAX_MS - 1));
         do_react(t0, t, $urandom_range(0, P - 1), 1'b0);
      end

      // False start during the second lamp.
      repeat ($urandom_range(1, 40)) @(negedge clk);
      start_run(e0, t0);
      wait_cyc(e0 + 2 * STEP + 5);
      check("fs_pre_lights", 32'(lights), 3);
      react = 1'b1;
      @(negedge clk);
      check("fs_lights", 32'(lights), 0);
      check("fs_flag", 32'(false_start), 1);
      check("fs_busy", 32'(busy), 0);
      check("fs_time_held", 32'(time_ms), time_model);
      check("fs_no_valid", 32'(time_valid), 0);
      repeat (5) @(negedge clk);
      check("fs_still", 32'(false_start), 1);

      // React held high through the whole run: no edge, so the timer saturates.
      start_run(e0, t0);
      wait_cyc(t0 + P * MAX_MS + P - 1);
      check("sat_pre_busy", 32'(busy), 1);
      check("sat_pre_ovf", 32'(overflow), 0);
      @(negedge clk);
      check("sat_ovf", 32'(overflow), 1);
      check("sat_time", 32'(time_ms), MAX_MS);
      check("sat_valid", 32'(time_valid), 0);
      check("sat_best", 32'(best_ms), best_model);
      check("sat_busy", 32'(busy), 0);
      time_model = MAX_MS;
      react = 1'b0;

      // React edge on the saturation tick wins.
      repeat ($urandom_range(2, 40)) @(negedge clk);
      start_run(e0, t0);
      check("ovf_cleared", 32'(overflow), 0);
      do_react(t0, MAX_MS, P - 1, 1'b0);
      check("react_wins_ovf", 32'(overflow), 0);

      // clear_best coincident with a valid time, then best rebuilt.
      repeat ($urandom_range(1, 40)) @(negedge clk);
      start_run(e0, t0);
      do_react(t0, $urandom_range(0, MAX_MS - 1), $urandom_range(0, P - 1), 1'b1);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      start_run(e0, t0);
      do_react(t0, $urandom_range(0, MAX_MS - 1), $urandom_range(0, P - 1), 1'b0);

      // Asynchronous reset while holding.
      repeat ($urandom_range(1, 40)) @(negedge clk);
      start_run(e0, t0);
      wait_cyc(e0 + STEP * (N_LIGHTS + 1) + 2 * P);
      check("hold_lights_rst", 32'(lights), ALL_ON);
      #2 rst_n = 1'b0;
      #1;
      check_reset("async");
      @(negedge clk);
      rst_n = 1'b1;
      best_model = MAX_MS;
      time_model = 0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
      start_run(e0, t0);
      do_react(t0, $urandom_range(0, MAX_MS - 1), $urandom_range(0, P - 1), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
